mips_io_ports: RTL and testbench

MIPS_IO_PORTS -- requirements
Module: mips_io_ports

---
 rtl/mips_io_pkg.sv | 18 +
 rtl/mips_io_ports_io_sync.sv | 34 +++
 rtl/mips_io_ports.sv | 126 ++++++++++++
 tb/tb_mips_io_ports.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_io_pkg.sv
// Shared constants for the memory-mapped I/O port block.
// Register offsets within a port window and global register indices.
package mips_io_pkg;

    localparam logic [1:0] OFS_OUT = 2'd0;
    localparam logic [1:0] OFS_SET = 2'd1;
    localparam logic [1:0] OFS_CLR = 2'd2;
    localparam logic [1:0] OFS_IN  = 2'd3;

    function automatic int unsigned flags_idx(input int unsigned n);
        return 4 * n;
    endfunction

    function automatic int unsigned irq_en_idx(input int unsigned n);
        return 4 * n + 1;
    endfunction

endpackage

// File: rtl/mips_io_ports_io_sync.sv
// Two-flop input synchronizer with a change-detect flag.
// o_chg is high while the synced value differs from the one before it.
module io_sync
    import mips_io_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q,
    output logic         o_chg
);

    logic [W-1:0] r_s1;
    logic [W-1:0] r_s2;
    logic [W-1:0] r_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_prev <= '0;
        end else begin
            r_s1   <= i_d;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign o_q   = r_s2;
    assign o_chg = (r_s2 != r_prev);

endmodule

// File: rtl/mips_io_ports.sv
// Memory-mapped output/input ports with change flags and interrupt.
// Each port owns a 4-word window; FLAGS and IRQ_EN follow the windows.
module mips_io_ports
    import mips_io_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int OUT_WIDTH  = 32,
    parameter int IN_WIDTH   = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [ADDR_WIDTH-1:0]          addr,
    input  logic [OUT_WIDTH-1:0]           wdata,
    input  logic                           we,
    input  logic                           re,
    output logic [OUT_WIDTH-1:0]           rdata,
    output logic                           rdata_valid,
    input  logic [NUM_PORTS*IN_WIDTH-1:0]  port_in,
    output logic [NUM_PORTS*OUT_WIDTH-1:0] port_out,
    output logic                           irq
);

    localparam int PW = ADDR_WIDTH - 2;
    localparam logic [ADDR_WIDTH-1:0] A_FLAGS =
        ADDR_WIDTH'(flags_idx(NUM_PORTS));
    localparam logic [ADDR_WIDTH-1:0] A_IRQ_EN =
        ADDR_WIDTH'(irq_en_idx(NUM_PORTS));

    logic [NUM_PORTS-1:0][OUT_WIDTH-1:0] r_out;
    logic [NUM_PORTS-1:0][IN_WIDTH-1:0]  w_in;
    logic [NUM_PORTS-1:0]                r_flags;
    logic [NUM_PORTS-1:0]                r_irq_en;
    logic [NUM_PORTS-1:0]                w_chg;
    logic [NUM_PORTS-1:0]                w_sel;
    logic [NUM_PORTS-1:0]                w_clr;
    logic [OUT_WIDTH-1:0]                w_rd;
    logic [OUT_WIDTH-1:0]                r_rdata;
    logic                                r_valid;
    logic                                r_irq;
    logic                                w_port_hit;
    logic [PW-1:0]                       w_pidx;
    logic [1:0]                          w_ofs;

    assign w_port_hit = (addr < A_FLAGS);
    assign w_pidx     = addr[ADDR_WIDTH-1:2];
    assign w_ofs      = addr[1:0];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        io_sync #(.W(IN_WIDTH)) u_sync (
            .clk   (clk),
            .reset (reset),
            .i_d   (port_in[p*IN_WIDTH +: IN_WIDTH]),
            .o_q   (w_in[p]),
            .o_chg (w_chg[p])
        );
    end

    always_comb begin
        w_sel = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_sel[p] = w_port_hit && (w_pidx == PW'(p));
        end
    end

    assign w_clr = (we && addr == A_FLAGS) ?
                   wdata[NUM_PORTS-1:0] : '0;

    // Read mux sees pre-write state, so a same-cycle write is not visible
    always_comb begin
        w_rd = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_sel[p]) begin
                case (w_ofs)
                    OFS_OUT: w_rd = r_out[p];
                    OFS_IN:  w_rd = OUT_WIDTH'(w_in[p]);
                    default: w_rd = '0;
                endcase
            end
        end
        if (addr == A_FLAGS) begin
            w_rd[NUM_PORTS-1:0] = r_flags;
        end
        if (addr == A_IRQ_EN) begin
            w_rd[NUM_PORTS-1:0] = r_irq_en;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out    <= '0;
            r_flags  <= '0;
            r_irq_en <= '0;
            r_irq    <= 1'b0;
            r_rdata  <= '0;
            r_valid  <= 1'b0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (we && w_sel[p]) begin
                    case (w_ofs)
                        OFS_OUT: r_out[p] <= wdata;
                        OFS_SET: r_out[p] <= r_out[p] | wdata;
                        OFS_CLR: r_out[p] <= r_out[p] & ~wdata;
                        default: ;
                    endcase
                end
            end
            // A fresh change outranks a clear landing on the same edge
            r_flags <= (r_flags & ~w_clr) | w_chg;
            if (we && addr == A_IRQ_EN) begin
                r_irq_en <= wdata[NUM_PORTS-1:0];
            end
            r_irq   <= |(r_flags & r_irq_en);
            r_valid <= re;
            if (re) begin
                r_rdata <= w_rd;
            end
        end
    end

    assign port_out    = r_out;
    assign rdata       = r_rdata;
    assign rdata_valid = r_valid;
    assign irq         = r_irq;

endmodule

// File: tb/tb_mips_io_ports.sv
// Self-checking bench for mips_io_ports against a behavioural model.
// Directed scenarios first, then a randomized bus/input soak.
module tb_mips_io_ports;

    localparam int NP = 4;
    localparam int OW = 32;
    localparam int IW = 8;
    localparam int AW = 6;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [AW-1:0]     addr = '0;
    logic [OW-1:0]     wdata = '0;
    logic              we = 1'b0;
    logic              re = 1'b0;
    logic [OW-1:0]     rdata;
    logic              rdata_valid;
    logic [NP*IW-1:0]  port_in = '0;
    logic [NP*OW-1:0]  port_out;
    logic              irq;

    int checks = 0;
    int errors = 0;

    // Model state: sample history per port, newest first
    logic [31:0] m_out [NP];
    logic [3:0]  m_flags;
    logic [3:0]  m_en;
    logic        m_irq;
    logic [31:0] m_rdata;
    logic        m_valid;
    logic [7:0]  hist [NP][4];

    mips_io_ports #(
        .NUM_PORTS  (NP),
        .OUT_WIDTH  (OW),
        .IN_WIDTH   (IW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .addr        (addr),
        .wdata       (wdata),
        .we          (we),
        .re          (re),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .port_in     (port_in),
        .port_out    (port_out),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_read(input int a);
        logic [31:0] v;
        v = 32'h0;
        if (a < 4 * NP) begin
            if (a % 4 == 0) v = m_out[a / 4];
            if (a % 4 == 3) v = {24'h0, hist[a / 4][1]};
        end else if (a == 4 * NP) begin
            v = {28'h0, m_flags};
        end else if (a == 4 * NP + 1) begin
            v = {28'h0, m_en};
        end
        return v;
    endfunction

    task automatic tick();
        logic [31:0] rd;
        logic [3:0]  chg;
        logic [3:0]  clr;
        int          a;
        a  = int'(addr);
        rd = model_read(a);
        if (reset) begin
            for (int p = 0; p < NP; p++) begin
                m_out[p] = 32'h0;
                for (int k = 0; k < 4; k++) hist[p][k] = 8'h0;
            end
            m_flags = 4'h0;
            m_en    = 4'h0;
            m_irq   = 1'b0;
            m_rdata = 32'h0;
            m_valid = 1'b0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                chg[p] = (hist[p][1] != hist[p][2]);
            end
            clr = (we && a == 4 * NP) ? wdata[3:0] : 4'h0;
            m_valid = re;
            if (re) m_rdata = rd;
            m_irq   = |(m_flags & m_en);
            m_flags = (m_flags & ~clr) | chg;
            if (we && a < 4 * NP) begin
                case (a % 4)
                    0: m_out[a / 4] = wdata;
                    1: m_out[a / 4] = m_out[a / 4] | wdata;
                    2: m_out[a / 4] = m_out[a / 4] & ~wdata;
                    default: ;
                endcase
            end
            if (we && a == 4 * NP + 1) m_en = wdata[3:0];
            for (int p = 0; p < NP; p++) begin
                for (int k = 3; k > 0; k--) hist[p][k] = hist[p][k-1];
                hist[p][0] = port_in[p*IW +: IW];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input logic w, input logic r,
                         input int a, input logic [31:0] d);
        we    = w;
        re    = r;
        addr  = AW'(a);
        wdata = d;
        tick();
        we = 1'b0;
        re = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (port_out !== '0) begin
            errors++;
            $display("FAIL reset_out got %h want 0", port_out);
        end
        checks++;
        if (irq !== 1'b0 || rdata_valid !== 1'b0 || rdata !== '0) begin
            errors++;
            $display("FAIL reset_ctl irq=%b vld=%b rdata=%h want 0",
                     irq, rdata_valid, rdata);
        end
        for (int a = 0; a < 18; a++) begin
            cycle(1'b0, 1'b1, a, 32'h0);
            checks++;
            if (rdata_valid !== 1'b1 || rdata !== 32'h0) begin
                errors++;
                $display("FAIL reset_read a=%0d vld=%b rdata=%h want 1/0",
                         a, rdata_valid, rdata);
            end
        end
        tick();
        checks++;
        if (rdata_valid !== 1'b0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL idle_vld vld=%b irq=%b want 0/0",
                     rdata_valid, irq);
        end
    endtask

    task automatic test_out_set_clr();
        cycle(1'b1, 1'b0, 4, 32'h0000_00F0);
        checks++;
        if (port_out[63:32] !== 32'hF0) begin
            errors++;
            $display("FAIL out_wr got %h want f0", port_out[63:32]);
        end
        cycle(1'b1, 1'b0, 5, 32'h0000_000F);
        checks++;
        if (port_out[63:32] !== 32'hFF) begin
            errors++;
            $display("FAIL out_set got %h want ff", port_out[63:32]);
        end
        cycle(1'b1, 1'b0, 6, 32'h0000_0030);
        checks++;
        if (port_out[63:32] !== 32'hCF) begin
            errors++;
            $display("FAIL out_clr got %h want cf", port_out[63:32]);
        end
        cycle(1'b0, 1'b1, 4, 32'h0);
        checks++;
        if (rdata !== 32'h0000_00CF || rdata_valid !== 1'b1) begin
            errors++;
            $display("FAIL out_rd got %h want 000000cf", rdata);
        end
        cycle(1'b0, 1'b1, 5, 32'h0);
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL wo_rd got %h want 0", rdata);
        end
    endtask

    task automatic test_input_irq();
        cycle(1'b1, 1'b0, 17, 32'h4);
        port_in[23:16] = 8'h5A;
        tick();
        tick();
        cycle(1'b0, 1'b1, 11, 32'h0);
        checks++;
        if (rdata !== 32'h5A) begin
            errors++;
            $display("FAIL in_rd got %h want 5a", rdata);
        end
        cycle(1'b0, 1'b1, 16, 32'h0);
        checks++;
        if (rdata !== 32'h4) begin
            errors++;
            $display("FAIL flags_rd got %h want 4", rdata);
        end
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_set got %b want 1", irq);
        end
        cycle(1'b1, 1'b0, 16, 32'h4);
        tick();
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_clr got %b want 0", irq);
        end
    endtask

    task automatic test_set_wins();
        port_in[7:0] = 8'h11;
        tick();
        tick();
        cycle(1'b1, 1'b0, 16, 32'h1);
        cycle(1'b0, 1'b1, 16, 32'h0);
        checks++;
        if (rdata[0] !== 1'b1) begin
            errors++;
            $display("FAIL set_wins got %b want 1", rdata[0]);
        end
        cycle(1'b1, 1'b0, 16, 32'hF);
        cycle(1'b0, 1'b1, 16, 32'h0);
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL w1c got %h want 0", rdata);
        end
    endtask

    task automatic test_we_re();
        cycle(1'b1, 1'b0, 0, 32'h99);
        cycle(1'b1, 1'b1, 0, 32'h1234);
        checks++;
        if (rdata !== 32'h99) begin
            errors++;
            $display("FAIL we_re_old got %h want 99", rdata);
        end
        cycle(1'b0, 1'b1, 0, 32'h0);
        checks++;
        if (rdata !== 32'h1234) begin
            errors++;
            $display("FAIL we_re_new got %h want 1234", rdata);
        end
    endtask

    task automatic test_reset_read();
        cycle(1'b1, 1'b0, 12, 32'hFFFF_FFFF);
        checks++;
        if (port_out[127:96] !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL p3_wr got %h want ffffffff", port_out[127:96]);
        end
        re    = 1'b1;
        addr  = AW'(12);
        reset = 1'b1;
        tick();
        re    = 1'b0;
        reset = 1'b0;
        checks++;
        if (rdata_valid !== 1'b0 || port_out !== '0) begin
            errors++;
            $display("FAIL rst_drop vld=%b out=%h want 0/0",
                     rdata_valid, port_out);
        end
        tick();
        checks++;
        if (rdata_valid !== 1'b0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_after vld=%b rdata=%h want 0/0",
                     rdata_valid, rdata);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            we    = ($urandom_range(0, 2) == 0);
            re    = ($urandom_range(0, 1) == 0);
            addr  = AW'($urandom_range(0, 21));
            wdata = $urandom;
            reset = ($urandom_range(0, 199) == 0);
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(0, 5) == 0) begin
                    port_in[p*IW +: IW] = IW'($urandom);
                end
            end
            tick();
            for (int p = 0; p < NP; p++) begin
                checks++;
                if (port_out[p*OW +: OW] !== m_out[p]) begin
                    errors++;
                    $display("FAIL rnd_out n=%0d p=%0d got %h want %h",
                             n, p, port_out[p*OW +: OW], m_out[p]);
                end
            end
            checks++;
            if (rdata_valid !== m_valid || rdata !== m_rdata) begin
                errors++;
                $display("FAIL rnd_rd n=%0d got %b/%h want %b/%h",
                         n, rdata_valid, rdata, m_valid, m_rdata);
            end
            checks++;
            if (irq !== m_irq) begin
                errors++;
                $display("FAIL rnd_irq n=%0d got %b want %b",
                         n, irq, m_irq);
            end
        end
        we    = 1'b0;
        re    = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_out_set_clr();
        test_input_irq();
        test_set_wins();
        test_we_re();
        test_reset_read();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
